fios_mm_seq: RTL
================

FIOS_MM_SEQ -- requirements
Module: fios_mm_seq

Interface
REQ-001 SHALL have parameter WORD_W, default 17, giving the word width in bits (range 8..32).
REQ-002 SHALL have parameter S, default 8, giving the number of words per operand (range 2..64).
REQ-003 SHALL have port clock_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1 bit: request a multiplication; sampled only in IDLE.
REQ-006 SHALL have port p_prime_0_i, input, WORD_W bits: -p^-1 mod 2^WORD_W.
REQ-007 SHALL have ports a_i, b_i and p_i, each input, S*WORD_W bits: operands and modulus, word 0 at the LSBs.
REQ-008 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle pulse when res_o becomes valid.
REQ-010 SHALL have port res_o, output, S*WORD_W bits: the Montgomery product.

Function
REQ-011 SHALL compute res_o ≡ a*b*R^-1 mod p, where R = 2^(WORD_W*S), given odd p, a < p and b < p.
REQ-012 SHALL implement the FSM states IDLE, LOAD, MUL, SUB and DONE.
REQ-013 SHALL transition as follows: IDLE→LOAD when start_i=1; LOAD→MUL after 1 cycle; MUL→SUB (macro defined) or MUL→DONE (macro undefined) after S*(S+1) cycles; SUB→DONE after S+1 cycles; DONE→IDLE after 1 cycle.
REQ-014 SHALL, in LOAD, register a_i, b_i, p_i and p_prime_0_i, and clear the accumulator t (S+2 words) to 0; later input changes SHALL have no effect until the next start.
REQ-015 SHALL, in MUL, run outer index i = 0..S-1, each spanning S+1 cycles.
REQ-016 SHALL, in inner cycle j = 0..S-1 of MUL, perform one word multiply-accumulate of a[j]*b[i] + m*p[j] + t[j] + carry.
REQ-017 SHALL, at j = 0, form m = ((t0 + a0*b[i]) * p') mod 2^WORD_W combinationally within the same cycle.
REQ-018 SHALL, in cycle S of each outer iteration, fold the carry into t[S] and t[S+1] and shift t down by one word.
REQ-019 SHALL size every intermediate sum with no overflow: at least 2*WORD_W+2 bits.
REQ-020 SHALL assert done_o for exactly one cycle, in DONE.
REQ-021 SHALL update res_o on the same edge that enters DONE, and hold it unchanged until the next entry into DONE.
REQ-022 SHALL give a latency, measured from the edge sampling start_i=1 to the cycle with done_o=1, of 2 + S*(S+1) cycles, plus S+1 cycles when the macro is defined.
REQ-023 SHALL ignore start_i while busy_o=1, with no queuing.
REQ-024 SHALL accept start_i held high continuously as back-to-back requests, one per return to IDLE.
REQ-025 SHALL produce res_o = 0 when a = 0 or b = 0.

Reset
REQ-026 SHALL, with reset_i=1 at a rising edge, force IDLE, busy_o=0, done_o=0, res_o=0, and clear all counters and the accumulator.
REQ-027 SHALL, on reset mid-operation in any state, abandon the computation with no done_o pulse; start_i SHALL be accepted on the first edge after reset_i deasserts.
REQ-028 SHALL give reset priority over start_i when both are high.

Configuration
REQ-029 SHALL use the macro FIOS_MM_FINAL_SUB_EN to control the final subtraction.
REQ-030 SHALL, when the macro is defined, include SUB: S cycles of word-serial t - p with a borrow chain, then 1 select cycle that outputs t - p if t ≥ p (no final borrow or t[S] ≠ 0), else t; res_o < p is guaranteed.
REQ-031 SHALL, when the macro is undefined, omit SUB logic and output t[S-1:0] directly; res_o < 2p only, with res_o ≡ expected mod p.

Verification
REQ-032 SHALL cover: S=2, W=17, p=0x2_0000_0001, p'=0x1FFFF, a=0x1_FFFF_FFFF (R mod p), b=5 -> res_o=5; done_o at cycle 8 (undefined) / 11 (defined).
REQ-033 SHALL cover: same p, a=0, b=0x1234 -> res_o=0 and a single done_o pulse.
REQ-034 SHALL cover: start_i pulsed again at cycle 3 of MUL -> ignored; exactly one done_o; result unchanged.
REQ-035 SHALL cover: reset_i asserted mid-MUL for 1 cycle -> busy_o=0 and res_o=0 on the next cycle; no done_o; a new start gives the correct result.
REQ-036 SHALL cover: S=8, W=17, 1000 random odd p with a,b < p against a golden model -> with the macro, res_o exact and < p; without it, res_o mod p matches and res_o < 2p.
REQ-037 SHALL cover: start_i held high for 3 operations -> done_o pulses spaced exactly latency+1 cycles apart.

Source files
------------

// File: rtl/fios_mm_seq.sv
// fios_mm_seq: word-serial FIOS Montgomery multiplier, one word multiply-accumulate per cycle.
// Optional final conditional subtraction enabled by defining FIOS_MM_FINAL_SUB_EN.
module fios_mm_seq #(
    parameter int WORD_W = 17,
    parameter int S      = 8
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [WORD_W-1:0]   p_prime_0_i,
    input  logic [S*WORD_W-1:0] a_i,
    input  logic [S*WORD_W-1:0] b_i,
    input  logic [S*WORD_W-1:0] p_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [S*WORD_W-1:0] res_o
);
    localparam int W  = WORD_W;
    localparam int SW = 2 * W + 2;
    localparam int IW = $clog2(S);
    localparam int CW = $clog2(S + 1);
    localparam logic [CW-1:0] J_LAST = CW'(S);
    localparam logic [IW-1:0] I_LAST = IW'(S - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MUL, SUB, DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]   a_w [S];
    logic [W-1:0]   b_w [S];
    logic [W-1:0]   p_w [S];
    logic [W-1:0]   t_w [S];
    logic [W-1:0]   t_sh [S];
    logic [W-1:0]   t_hi, t_sh_hi, pp, m_r;
    logic [W+1:0]   carry;
    logic [IW-1:0]  i_cnt, jx;
    logic [CW-1:0]  j_cnt;
    logic           last_j;

    logic [W-1:0]   aj, bi, pj, tj, u, m_c, m;
    logic [2*W-1:0] ab, mp;
    logic [SW-1:0]  sum;
    logic [W+2:0]   fold;

    always_comb begin
        jx     = j_cnt[IW-1:0];
        last_j = (j_cnt == J_LAST);
        aj     = a_w[jx];
        bi     = b_w[i_cnt];
        pj     = p_w[jx];
        tj     = t_w[jx];
        ab     = aj * bi;
        // m makes the low word of the j=0 sum vanish
        u      = tj + ab[W-1:0];
        m_c    = u * pp;
        m      = (j_cnt == '0) ? m_c : m_r;
        mp     = m * pj;
        sum    = SW'(ab) + SW'(mp) + SW'(tj) + SW'(carry);
        fold   = {3'b000, t_hi} + {1'b0, carry};
        for (int k = 0; k < S - 1; k++) begin
            t_sh[k] = t_w[k+1];
        end
        t_sh[S-1] = fold[W-1:0];
        t_sh_hi   = {{(W-3){1'b0}}, fold[W+2:W]};
    end

`ifdef FIOS_MM_FINAL_SUB_EN
    logic [W-1:0]   d_w [S];
    logic           borrow;
    logic [W:0]     dif;
    logic [S*W-1:0] t_pk, d_pk;

    always_comb begin
        dif  = {1'b0, tj} - {1'b0, pj} - {{W{1'b0}}, borrow};
        t_pk = '0;
        d_pk = '0;
        for (int k = 0; k < S; k++) begin
            t_pk[k*W +: W] = t_w[k];
            d_pk[k*W +: W] = d_w[k];
        end
    end
`else
    logic [S*W-1:0] sh_pk;

    always_comb begin
        sh_pk = '0;
        for (int k = 0; k < S; k++) begin
            sh_pk[k*W +: W] = t_sh[k];
        end
    end
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy_o   = 1'b1;
        done_o   = 1'b0;
        unique case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nx = LOAD;
            end
            LOAD: state_nx = MUL;
            MUL: begin
                if (last_j && i_cnt == I_LAST)
`ifdef FIOS_MM_FINAL_SUB_EN
                    state_nx = SUB;
            end
            SUB: begin
                if (last_j) state_nx = DONE;
`else
                    state_nx = DONE;
`endif
            end
            DONE: begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int k = 0; k < S; k++) begin
                a_w[k] <= '0;
                b_w[k] <= '0;
                p_w[k] <= '0;
                t_w[k] <= '0;
            end
            t_hi  <= '0;
            pp    <= '0;
            m_r   <= '0;
            carry <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            res_o <= '0;
`ifdef FIOS_MM_FINAL_SUB_EN
            for (int k = 0; k < S; k++) d_w[k] <= '0;
            borrow <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    for (int k = 0; k < S; k++) begin
                        a_w[k] <= a_i[k*W +: W];
                        b_w[k] <= b_i[k*W +: W];
                        p_w[k] <= p_i[k*W +: W];
                        t_w[k] <= '0;
                    end
                    pp    <= p_prime_0_i;
                    t_hi  <= '0;
                    carry <= '0;
                    i_cnt <= '0;
                    j_cnt <= '0;
`ifdef FIOS_MM_FINAL_SUB_EN
                    borrow <= 1'b0;
`endif
                end
                MUL: begin
                    if (last_j) begin
                        for (int k = 0; k < S; k++) t_w[k] <= t_sh[k];
                        t_hi  <= t_sh_hi;
                        carry <= '0;
                        j_cnt <= '0;
                        i_cnt <= i_cnt + 1'b1;
`ifndef FIOS_MM_FINAL_SUB_EN
                        if (i_cnt == I_LAST) res_o <= sh_pk;
`endif
                    end else begin
                        t_w[jx] <= sum[W-1:0];
                        carry   <= sum[SW-1:W];
                        if (j_cnt == '0) m_r <= m_c;
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
`ifdef FIOS_MM_FINAL_SUB_EN
                SUB: begin
                    if (last_j) begin
                        res_o <= (!borrow || t_hi != '0) ? d_pk : t_pk;
                    end else begin
                        d_w[jx] <= dif[W-1:0];
                        borrow  <= dif[W];
                        j_cnt   <= j_cnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
